// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - shared FSM state type and ceil-log2 helper for the posit layer blocks
package posit_defines;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/positron_layer_serializer.sv
// rtl/positron_layer_serializer.sv - gathers one result per positron, then streams the window out in index order
module positron_layer_serializer
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH  = 4,
  parameter int NB_POSITRONS = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NB_POSITRONS-1:0]             rts_i,
  input  logic [NB_POSITRONS-1:0]             eow_i,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0] posit_i,
  output logic [NB_POSITRONS-1:0]             rtr_o,
  input  logic                                rtr_i,
  output logic                                rts_o,
  output logic                                sow_o,
  output logic                                eow_o,
  output logic [POSIT_WIDTH-1:0]              posit_o,
  output logic                                layer_done_o
);

  localparam int IDX_W = log2_ceil(NB_POSITRONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRONS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NB_POSITRONS-1:0] valid_q, valid_d;
  logic [NB_POSITRONS-1:0] rtr_q;
  logic [NB_POSITRONS-1:0] cap;
  logic [NB_POSITRONS-1:0] clr;
  logic                    done_d, done_q;
  logic [POSIT_WIDTH-1:0]  res_q [NB_POSITRONS];

  // Only final (end-of-window) results are stored; partial handshakes are acked and dropped.
  assign cap = rts_i & eow_i & rtr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = '0;
    done_d  = 1'b0;
    rts_o   = 1'b0;
    sow_o   = 1'b0;
    eow_o   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (&valid_q) begin
          state_d = EMIT;
          idx_d   = '0;
        end
      end
      EMIT: begin
        rts_o = 1'b1;
        sow_o = (idx_q == '0);
        eow_o = (idx_q == LAST_IDX);
        if (rtr_i) begin
          clr[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = COLLECT;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // rtr_q tracks ~valid_d so a slot freed this cycle can't also be captured this cycle.
  assign valid_d = (valid_q | cap) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      valid_q <= '0;
      rtr_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      rtr_q   <= ~valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB_POSITRONS; k++) begin
      if (cap[k]) res_q[k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
    end
  end

  assign posit_o      = res_q[idx_q];
  assign rtr_o        = rtr_q;
  assign layer_done_o = done_q;

endmodule

// File: tb/tb_positron_layer_serializer.sv
// tb/tb_positron_layer_serializer.sv - directed self-checking bench for positron_layer_serializer (4 x 4-bit)
module tb_positron_layer_serializer;

  localparam int W  = 4;
  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] rts_i;
  logic [NB-1:0] eow_i;
  logic [NB*W-1:0] posit_i;
  logic [NB-1:0] rtr_o;
  logic          rtr_i;
  logic          rts_o;
  logic          sow_o;
  logic          eow_o;
  logic [W-1:0]  posit_o;
  logic          layer_done_o;

  int checks;
  int errors;

  positron_layer_serializer #(.POSIT_WIDTH(W), .NB_POSITRONS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rts_i        (rts_i),
    .eow_i        (eow_i),
    .posit_i      (posit_i),
    .rtr_o        (rtr_o),
    .rtr_i        (rtr_i),
    .rts_o        (rts_o),
    .sow_o        (sow_o),
    .eow_o        (eow_o),
    .posit_o      (posit_o),
    .layer_done_o (layer_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one handshake for a single cycle, then drop it; returns at the next negedge.
  task automatic deliver(input int k, input logic [W-1:0] v, input logic eow);
    rts_i = '0;
    eow_i = '0;
    rts_i[k] = 1'b1;
    eow_i[k] = eow;
    posit_i[k*W +: W] = v;
    @(negedge clk);
    rts_i = '0;
    eow_i = '0;
  endtask

  task automatic exp_word(input string tag, input logic [W-1:0] v, input logic s, input logic e);
    chk({tag, "_rts"}, 32'(rts_o), 32'h1);
    chk({tag, "_posit"}, 32'(posit_o), 32'(v));
    chk({tag, "_sow"}, 32'(sow_o), 32'(s));
    chk({tag, "_eow"}, 32'(eow_o), 32'(e));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    rts_i   = '0;
    eow_i   = '0;
    posit_i = '0;
    rtr_i   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rtr", 32'(rtr_o), 32'hF);
    chk("rst_rts", 32'(rts_o), 32'h0);
    chk("rst_sow", 32'(sow_o), 32'h0);
    chk("rst_eow", 32'(eow_o), 32'h0);
    chk("rst_done", 32'(layer_done_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window, reverse delivery, downstream always ready
    deliver(3, 4'h4, 1'b1);
    chk("t1_rtr_a", 32'(rtr_o), 32'h7);
    deliver(2, 4'h3, 1'b1);
    chk("t1_rtr_b", 32'(rtr_o), 32'h3);
    deliver(1, 4'h2, 1'b1);
    deliver(0, 4'h1, 1'b1);
    chk("t1_rtr_full", 32'(rtr_o), 32'h0);
    chk("t1_rts_pre", 32'(rts_o), 32'h0);
    @(negedge clk);
    exp_word("t1_w0", 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t1_w1", 4'h2, 1'b0, 1'b0);
    chk("t1_rtr_freed", 32'(rtr_o), 32'h1);
    chk("t1_done_mid", 32'(layer_done_o), 32'h0);
    @(negedge clk);
    exp_word("t1_w2", 4'h3, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t1_w3", 4'h4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_rts_end", 32'(rts_o), 32'h0);
    chk("t1_done", 32'(layer_done_o), 32'h1);
    chk("t1_rtr_end", 32'(rtr_o), 32'hF);
    @(negedge clk);
    chk("t1_done_clr", 32'(layer_done_o), 32'h0);

    // Downstream stall for three cycles at idx=2
    deliver(3, 4'h4, 1'b1);
    deliver(2, 4'h3, 1'b1);
    deliver(1, 4'h2, 1'b1);
    deliver(0, 4'h1, 1'b1);
    @(negedge clk);
    exp_word("t2_w0", 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t2_w1", 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t2_w2", 4'h3, 1'b0, 1'b0);
    rtr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_word("t2_hold", 4'h3, 1'b0, 1'b0);
    end
    rtr_i = 1'b1;
    @(negedge clk);
    exp_word("t2_w3", 4'h4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_rts_end", 32'(rts_o), 32'h0);
    chk("t2_done", 32'(layer_done_o), 32'h1);

    // Overlap: positron 0 re-delivers while idx=2
    deliver(3, 4'h4, 1'b1);
    deliver(2, 4'h3, 1'b1);
    deliver(1, 4'h2, 1'b1);
    deliver(0, 4'h1, 1'b1);
    @(negedge clk);
    exp_word("t3_w0", 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t3_w1", 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t3_w2", 4'h3, 1'b0, 1'b0);
    deliver(0, 4'h7, 1'b1);
    exp_word("t3_w3", 4'h4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_done", 32'(layer_done_o), 32'h1);
    chk("t3_rtr_wait", 32'(rtr_o), 32'hE);
    chk("t3_rts_wait", 32'(rts_o), 32'h0);
    deliver(1, 4'h8, 1'b1);
    deliver(2, 4'h9, 1'b1);
    deliver(3, 4'hA, 1'b1);
    chk("t3_rts_pre", 32'(rts_o), 32'h0);
    @(negedge clk);
    exp_word("t3_n0", 4'h7, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t3_n1", 4'h8, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t3_n2", 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t3_n3", 4'hA, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_done2", 32'(layer_done_o), 32'h1);

    // Partial result dropped, and a second delivery to a full slot refused
    deliver(0, 4'h5, 1'b1);
    deliver(1, 4'h6, 1'b1);
    deliver(3, 4'hC, 1'b1);
    deliver(2, 4'hE, 1'b0);
    chk("t4_rtr_partial", 32'(rtr_o), 32'h4);
    @(negedge clk);
    chk("t4_no_emit", 32'(rts_o), 32'h0);
    deliver(1, 4'hF, 1'b1);
    chk("t4_rtr_busy", 32'(rtr_o), 32'h4);
    chk("t4_no_emit2", 32'(rts_o), 32'h0);
    deliver(2, 4'hB, 1'b1);
    @(negedge clk);
    exp_word("t4_w0", 4'h5, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t4_w1", 4'h6, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t4_w2", 4'hB, 1'b0, 1'b0);
    @(negedge clk);
    exp_word("t4_w3", 4'hC, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_done", 32'(layer_done_o), 32'h1);

    // Reset mid-window abandons it
    deliver(3, 4'h4, 1'b1);
    deliver(2, 4'h3, 1'b1);
    deliver(1, 4'h2, 1'b1);
    deliver(0, 4'h1, 1'b1);
    @(negedge clk);
    exp_word("t5_w0", 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    exp_word("t5_w1", 4'h2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rts", 32'(rts_o), 32'h0);
    chk("t5_rst_rtr", 32'(rtr_o), 32'hF);
    chk("t5_rst_eow", 32'(eow_o), 32'h0);
    chk("t5_rst_sow", 32'(sow_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_post_eow", 32'(eow_o), 32'h0);
      chk("t5_post_rts", 32'(rts_o), 32'h0);
      chk("t5_post_done", 32'(layer_done_o), 32'h0);
    end
    chk("t5_post_rtr", 32'(rtr_o), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
